stub_page_buffer: RTL and testbench

Parametrised, multi-page stub memory for one layer/disk input stream of the tracklet pipeline. Each bunch crossing (BX) gets its own page. Stubs arriving with `enable` are packed contiguously into the current page, and a per-page count is kept. Downstream engines read any page by page index plus address. The block replaces the fixed two-page, 36-bit layer memory: it adds configurable width, depth and page count, saturating overflow protection with sticky flags, and per-page count readback.

---
 rtl/stub_page_buffer.sv | 133 +++++++++++++
 tb/tb_stub_page_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stub_page_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stub_page_buffer
// Purpose  : Paged stub memory, one page per BX, saturating per-page counts.
// Revision : 1.0
// ============================================================================
module stub_page_buffer #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_BITS  = 6,
   parameter int PAGE_BITS  = 1,
   parameter int DONE_DELAY = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            start,
   output logic [1:0]            done,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  enable,
   input  logic [PAGE_BITS-1:0]  read_page,
   input  logic [ADDR_BITS-1:0]  read_add,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_BITS:0]    number_out,
   output logic                  overflow_out,
   output logic [PAGE_BITS-1:0]  wr_page_out
);

   localparam int                   c_NPAGES    = 2**PAGE_BITS;
   localparam int                   c_MEM_WORDS = 2**(PAGE_BITS+ADDR_BITS);
   localparam logic [PAGE_BITS-1:0] c_LAST_PAGE = '1;

   logic [DATA_WIDTH-1:0]          r_data_d1;
   logic                           r_enable_d1;
   logic [PAGE_BITS-1:0]           r_wr_page;
   logic [ADDR_BITS:0]             r_count [c_NPAGES];
   logic                           r_ovf   [c_NPAGES];
   logic [DATA_WIDTH-1:0]          r_mem   [c_MEM_WORDS];
   logic [DATA_WIDTH-1:0]          r_ram_q;
   logic [DATA_WIDTH-1:0]          r_data_out;
   logic [ADDR_BITS:0]             r_number_out;
   logic                           r_overflow_out;
   logic [1:0]                     r_done_pipe [DONE_DELAY];

   logic                           w_clear;
   logic                           w_write;
   logic                           w_has_room;
   logic                           w_mem_we;
   logic [ADDR_BITS:0]             w_wr_count;
   logic [PAGE_BITS-1:0]           w_next_page;
   logic [PAGE_BITS+ADDR_BITS-1:0] w_wr_addr;
   logic [PAGE_BITS+ADDR_BITS-1:0] w_rd_addr;

   assign w_clear     = reset | start[1];
   assign w_write     = r_enable_d1 & ~w_clear & ~start[0];
   assign w_wr_count  = r_count[r_wr_page];
   // Counts never exceed DEPTH, so the MSB alone flags a full page.
   assign w_has_room  = ~w_wr_count[ADDR_BITS];
   assign w_mem_we    = w_write & w_has_room;
   assign w_next_page = r_wr_page + PAGE_BITS'(1);
   assign w_wr_addr   = {r_wr_page, w_wr_count[ADDR_BITS-1:0]};
   assign w_rd_addr   = {read_page, read_add};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_d1   <= '0;
         r_enable_d1 <= 1'b0;
      end else begin
         r_data_d1   <= data_in;
         r_enable_d1 <= enable;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_wr_page <= c_LAST_PAGE;
         for (int p = 0; p < c_NPAGES; p++) begin
            r_count[p] <= '0;
            r_ovf[p]   <= 1'b0;
         end
      end else if (start[0]) begin
         r_wr_page            <= w_next_page;
         r_count[w_next_page] <= '0;
         r_ovf[w_next_page]   <= 1'b0;
      end else if (w_write) begin
         if (w_has_room) begin
            r_count[r_wr_page] <= w_wr_count + (ADDR_BITS+1)'(1);
         end else begin
            r_ovf[r_wr_page] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_wr_addr] <= r_data_d1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_ram_q        <= '0;
         r_data_out     <= '0;
         r_number_out   <= '0;
         r_overflow_out <= 1'b0;
      end else begin
         r_ram_q        <= r_mem[w_rd_addr];
         r_data_out     <= r_ram_q;
         r_number_out   <= r_count[read_page];
         r_overflow_out <= r_ovf[read_page];
      end
   end

   // Only a true reset flushes the latency line; start[1] travels through it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DONE_DELAY; i++) begin
            r_done_pipe[i] <= 2'b00;
         end
      end else begin
         r_done_pipe[0] <= start;
         for (int i = 1; i < DONE_DELAY; i++) begin
            r_done_pipe[i] <= r_done_pipe[i-1];
         end
      end
   end

   assign done         = r_done_pipe[DONE_DELAY-1];
   assign data_out     = r_data_out;
   assign number_out   = r_number_out;
   assign overflow_out = r_overflow_out;
   assign wr_page_out  = r_wr_page;

endmodule
`default_nettype wire

// File: tb/tb_stub_page_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stub_page_buffer
// Purpose  : Directed bench for stub_page_buffer (2-page and 4-page builds).
// Revision : 1.0
// ============================================================================
module tb_stub_page_buffer;

   localparam int DW = 36;
   localparam int AB = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, enable, overflow_out;
   logic [1:0]    start, done;
   logic [DW-1:0] data_in, data_out;
   logic [0:0]    read_page, wr_page_out;
   logic [AB-1:0] read_add;
   logic [AB:0]   number_out;

   logic          reset4, enable4, overflow_out4;
   logic [1:0]    start4, done4;
   logic [DW-1:0] data_in4, data_out4;
   logic [1:0]    read_page4, wr_page_out4;
   logic [AB-1:0] read_add4;
   logic [AB:0]   number_out4;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] exp_pg [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   stub_page_buffer u_dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .data_in(data_in), .enable(enable), .read_page(read_page), .read_add(read_add),
      .data_out(data_out), .number_out(number_out), .overflow_out(overflow_out),
      .wr_page_out(wr_page_out)
   );

   stub_page_buffer #(.PAGE_BITS(2)) u_dut4 (
      .clk(clk), .reset(reset4), .start(start4), .done(done4),
      .data_in(data_in4), .enable(enable4), .read_page(read_page4), .read_add(read_add4),
      .data_out(data_out4), .number_out(number_out4), .overflow_out(overflow_out4),
      .wr_page_out(wr_page_out4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic feed_a(input int n, input logic [DW-1:0] base);
      for (int i = 1; i <= n; i++) begin
         enable  = 1'b1;
         data_in = base + DW'(i);
         tick();
      end
      enable = 1'b0;
      tick();
      tick();
   endtask

   task automatic feed_b(input int n, input logic [DW-1:0] base);
      for (int i = 1; i <= n; i++) begin
         enable4  = 1'b1;
         data_in4 = base + DW'(i);
         tick();
      end
      enable4 = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 2'b00; enable = 1'b0; data_in = '0; read_page = '0; read_add = '0;
      reset4 = 1'b1; start4 = 2'b00; enable4 = 1'b0; data_in4 = '0; read_page4 = '0; read_add4 = '0;
      tick();
      tick();
      check("rst_data_out", data_out, 0);
      check("rst_number_out", number_out, 0);
      check("rst_overflow_out", overflow_out, 0);
      check("rst_done", done, 0);
      check("rst_wr_page", wr_page_out, 1);
      check("rst_wr_page_4p", wr_page_out4, 3);
      reset = 1'b0;
      reset4 = 1'b0;

      // First BX: five stubs into page 0
      start = 2'b01; tick(); start = 2'b00;
      check("bx0_wr_page", wr_page_out, 0);
      feed_a(5, '0);
      read_page = 1'b0; read_add = '0;
      tick();
      check("bx0_count", number_out, 5);
      tick();
      check("bx0_data_a0", data_out, 1);
      for (int a = 1; a < 5; a++) begin
         read_add = AB'(a);
         tick();
         tick();
         check("bx0_data", data_out, 64'(a + 1));
      end

      // Second BX: 70 stubs saturate page 1
      start = 2'b01; tick(); start = 2'b00;
      check("bx1_wr_page", wr_page_out, 1);
      feed_a(70, 36'h100);
      read_page = 1'b1; read_add = 6'd63;
      tick();
      tick();
      check("ovf_count", number_out, 64);
      check("ovf_flag", overflow_out, 1);
      check("ovf_last_word", data_out, 36'h140);
      read_add = '0;
      tick();
      tick();
      check("ovf_first_word", data_out, 36'h101);
      read_page = 1'b0;
      tick();
      check("p0_count_held", number_out, 5);
      check("p0_ovf_held", overflow_out, 0);

      // Stub coincident with start[0] belongs to the new page
      start = 2'b01; enable = 1'b1; data_in = 36'hABC;
      tick();
      start = 2'b00; enable = 1'b0;
      check("coin_wr_page", wr_page_out, 0);
      tick();
      tick();
      read_page = 1'b0; read_add = '0;
      tick();
      check("coin_count", number_out, 1);
      check("coin_ovf_cleared", overflow_out, 0);
      tick();
      check("coin_data", data_out, 36'hABC);
      read_page = 1'b1;
      tick();
      check("coin_prev_count", number_out, 64);
      check("coin_prev_ovf", overflow_out, 1);

      // start[1] in the middle of a BX
      start = 2'b01; tick(); start = 2'b00;
      feed_a(7, 36'h200);
      check("mid_count", number_out, 7);
      start = 2'b10; tick(); start = 2'b00;
      check("pr_count", number_out, 0);
      check("pr_wr_page", wr_page_out, 1);
      check("pr_data_out", data_out, 0);
      check("pr_ovf", overflow_out, 0);
      tick();
      check("pr_count_live", number_out, 0);
      start = 2'b01; tick(); start = 2'b00;
      check("pr_next_page", wr_page_out, 0);

      // done latency
      reset = 1'b1; tick(); reset = 1'b0;
      start = 2'b01; tick(); start = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("done_pulse", done, (k == 5) ? 64'd1 : 64'd0);
      end
      start = 2'b10; tick(); start = 2'b00;
      repeat (4) tick();
      tick();
      check("done_pr_propagates", done, 2);
      tick();
      check("done_pr_single", done, 0);
      start = 2'b01; tick(); start = 2'b00;
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         tick();
         check("done_flushed", done, 0);
      end

      // Four-page build: overflow page 0, wrap back to it
      start4 = 2'b01; tick(); start4 = 2'b00;
      feed_b(65, '0);
      read_page4 = 2'd0;
      tick();
      check("p4_pre_ovf", overflow_out4, 1);
      repeat (3) begin
         start4 = 2'b01; tick(); start4 = 2'b00;
      end
      check("p4_pre_page", wr_page_out4, 3);
      for (int b = 0; b < 5; b++) begin
         start4 = 2'b01; tick(); start4 = 2'b00;
         check("p4_wr_page", wr_page_out4, exp_pg[b]);
         feed_b(b + 1, DW'(b * 16));
      end
      read_page4 = 2'd0;
      tick();
      check("p4_p0_count", number_out4, 5);
      check("p4_p0_ovf_cleared", overflow_out4, 0);
      for (int p = 1; p < 4; p++) begin
         read_page4 = 2'(p);
         tick();
         check("p4_count", number_out4, 64'(p + 1));
      end
      read_page4 = 2'd0; read_add4 = 6'd4;
      tick();
      tick();
      check("p4_p0_a4", data_out4, 36'h45);
      read_page4 = 2'd2; read_add4 = 6'd2;
      tick();
      tick();
      check("p4_p2_a2", data_out4, 36'h23);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
